// File: rtl/imem_fetch_ctrl.sv
// Byte-serial instruction fetch sequencer that owns the single instruction-memory port.
// Define IMEM_LOADER_EN to include the boot-loader write path (LOAD state and write pointer).
module imem_fetch_ctrl #(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] RESET_PC = 32'h0,
  localparam int         AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  input  logic          ld_done,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [31:0]   instr,
  output logic [31:0]   instr_pc,
  output logic          misalign_err,
  output logic [1:0]    dbg_state
);

  // Handshakes: a byte/instruction transfers on a rising edge where valid and ready are
  // both high; instr_valid and its payload then hold until that edge or a redirect.
  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

`ifdef IMEM_LOADER_EN
  localparam state_t RESET_STATE = S_LOAD;
`else
  localparam state_t RESET_STATE = S_FETCH;
`endif

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [1:0]    k_q, k_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   instr_pc_q, instr_pc_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] fetch_addr;

  // Only the low AW bits of pc+k reach the memory, so fetches wrap modulo DEPTH.
  assign fetch_addr = pc_q[AW-1:0] + AW'(k_q);

`ifdef IMEM_LOADER_EN
  logic [AW-1:0] wptr_q, wptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wptr_q <= '0;
    else        wptr_q <= wptr_d;
  end
`else
  logic unused_ld;
  assign unused_ld = ^{ld_valid, ld_data, ld_done};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      pc_q       <= RESET_PC;
      k_q        <= 2'd0;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      k_q        <= k_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    k_d        = k_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    mem_addr   = fetch_addr;
    mem_we     = 1'b0;
    mem_wdata  = 8'h00;
    ld_ready   = 1'b0;
`ifdef IMEM_LOADER_EN
    wptr_d     = wptr_q;
`endif
    case (state_q)
`ifdef IMEM_LOADER_EN
      S_LOAD: begin
        ld_ready = 1'b1;
        mem_addr = wptr_q;
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_wdata = ld_data;
          wptr_d    = wptr_q + 1'b1;
        end
        if (ld_done) begin
          state_d = S_FETCH;
          pc_d    = RESET_PC;
          k_d     = 2'd0;
        end
      end
`endif
      S_FETCH: begin
        // Big-endian assembly: the k=0 byte ends up in bits 31:24 after four shifts.
        instr_d = {instr_q[23:0], mem_rdata};
        k_d     = k_q + 2'd1;
        if (k_q == 2'd3) begin
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          pc_d    = pc_q + 32'd4;
          k_d     = 2'd0;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_ERR: valid_d = 1'b0;
      default: ;
    endcase

    // Redirect overrides everything above, including a same-cycle handshake's pc+4.
    if (redirect && (state_q == S_FETCH || state_q == S_HOLD)) begin
      valid_d    = 1'b0;
      instr_pc_d = instr_pc_q;
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d    = redirect_pc;
        k_d     = 2'd0;
        state_d = S_FETCH;
      end else begin
        state_d = S_ERR;
      end
    end
  end

  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign instr_valid  = valid_q;
  assign misalign_err = (state_q == S_ERR);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: a mode-level reference model with per-cycle output compare,
// an accepted-instruction scoreboard and literal pins for the documented scenarios.
module tb_imem_fetch_ctrl;
  localparam int          DEPTH    = 64;
  localparam int          AW       = 6;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int M_LOAD = 0, M_FETCH = 1, M_HOLD = 2, M_ERR = 3;
`ifdef IMEM_LOADER_EN
  localparam int START_MODE = M_LOAD;
  localparam bit LOADER     = 1'b1;
`else
  localparam int START_MODE = M_FETCH;
  localparam bit LOADER     = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata, mem_wdata, ld_data;
  logic          mem_we, ld_valid, ld_ready, ld_done, redirect;
  logic [31:0]   redirect_pc, instr, instr_pc;
  logic          instr_valid, instr_ready, misalign_err;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .misalign_err(misalign_err), .dbg_state(dbg_state)
  );

  // Physical memory driven by the DUT; ref_mem is what the model believes it holds.
  logic [7:0] phys_mem [DEPTH];
  logic [7:0] ref_mem  [DEPTH];
  assign mem_rdata = phys_mem[mem_addr];
  always @(posedge clk) if (mem_we) phys_mem[mem_addr] <= mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_mode, m_n, m_wptr;
  logic [31:0] m_pc, m_instr, m_instr_pc;
  logic        m_valid, m_err;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] r, b;
    r = 32'h0;
    for (int i = 0; i < 4; i++) begin
      b = a + i;
      r = {r[23:0], ref_mem[b[AW-1:0]]};
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = START_MODE; m_pc = RESET_PC; m_n = 0; m_wptr = 0;
      m_valid = 1'b0; m_err = 1'b0; m_instr = 32'h0; m_instr_pc = 32'h0;
    end else begin
      case (m_mode)
        M_LOAD: begin
          if (ld_valid) begin
            ref_mem[m_wptr] = ld_data;
            m_wptr = (m_wptr + 1) % DEPTH;
          end
          if (ld_done) begin
            m_mode = M_FETCH; m_pc = RESET_PC; m_n = 0;
          end
        end
        M_FETCH, M_HOLD: begin
          if (m_mode == M_HOLD && instr_ready) exp_q.push_back(m_instr);
          if (redirect) begin
            m_valid = 1'b0;
            if (redirect_pc % 4 == 0) begin
              m_pc = redirect_pc; m_n = 0; m_mode = M_FETCH;
            end else begin
              m_mode = M_ERR; m_err = 1'b1;
            end
          end else if (m_mode == M_FETCH) begin
            m_n++;
            if (m_n == 4) begin
              m_instr = word_at(m_pc); m_instr_pc = m_pc; m_valid = 1'b1;
              m_mode = M_HOLD; m_n = 0;
            end
          end else if (instr_ready) begin
            m_pc = m_pc + 4; m_valid = 1'b0; m_mode = M_FETCH; m_n = 0;
          end
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk) if (rst_n && instr_valid && instr_ready) got_q.push_back(instr);

  // ---------------- per-cycle compare ----------------
  bit            prev_hold = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [31:0]   fa;

  always @(negedge clk) begin
    if (rst_n) begin
      check("instr_valid", instr_valid, m_valid);
      if (m_valid) begin
        check("instr", instr, m_instr);
        check("instr_pc", instr_pc, m_instr_pc);
      end
      check("misalign_err", misalign_err, m_err);
      check("ld_ready", ld_ready, m_mode == M_LOAD);
      check("mem_we", mem_we, (m_mode == M_LOAD) && ld_valid);
      if (m_mode == M_LOAD && ld_valid) begin
        check("load_addr", mem_addr, m_wptr);
        check("load_wdata", mem_wdata, ld_data);
      end
      if (!LOADER) check("wdata_tied", mem_wdata, 8'h00);
      if (m_mode == M_FETCH) begin
        fa = m_pc + m_n;
        check("fetch_addr", mem_addr, fa[AW-1:0]);
      end
      if (m_mode == M_HOLD && prev_hold) check("hold_addr_frozen", mem_addr, prev_addr);
      prev_hold = (m_mode == M_HOLD);
      prev_addr = mem_addr;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Counts edges until instr_valid is seen; ends 2 time units after that edge.
  task automatic wait_valid(input int exp_cnt, input string name);
    int cnt;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!instr_valid && cnt < 20);
    check(name, cnt, exp_cnt);
    #1;
  endtask

  task automatic handshake();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect = 1'b1; redirect_pc = target;
    step();
    redirect = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ld_valid = 1'b0; ld_data = 8'h0; ld_done = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; instr_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      phys_mem[i] = 8'(i * 3 + 5);
      ref_mem[i]  = 8'(i * 3 + 5);
    end
    if (!LOADER)
      for (int i = 0; i < 8; i++) begin
        phys_mem[i] = 8'(i + 1);
        ref_mem[i]  = 8'(i + 1);
      end

    repeat (3) @(posedge clk);
    #2;
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_misalign_err", misalign_err, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_wdata", mem_wdata, 8'h00);
    check("rst_ld_ready", ld_ready, LOADER);
    rst_n = 1'b1;

    if (LOADER) begin
      for (int i = 1; i <= 7; i++) begin
        ld_valid = 1'b1; ld_data = 8'(i);
        step();
      end
      ld_data = 8'h08; ld_done = 1'b1;
      step();
      ld_valid = 1'b0; ld_done = 1'b0;
    end
    wait_valid(4, "first_latency");
    check("first_instr", instr, 32'h01020304);
    check("first_instr_pc", instr_pc, 32'h0);

    instr_ready = 1'b1;
    wait_valid(5, "next_latency");
    instr_ready = 1'b0;
    check("second_instr", instr, 32'h05060708);
    check("second_instr_pc", instr_pc, 32'h4);

    repeat (10) step();
    check("bp_valid", instr_valid, 1'b1);
    check("bp_instr", instr, 32'h05060708);
    check("bp_instr_pc", instr_pc, 32'h4);
    handshake();
    wait_valid(4, "after_bp_latency");
    check("after_bp_pc", instr_pc, 32'h8);
    check("after_bp_instr", instr, 32'h1D202326);

    for (int i = 0; i < 600; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = $urandom() & 32'hFFFF_FFFC;
      else                           redirect_pc = 32'($urandom_range(0, 31) * 4);
      ld_valid = $urandom_range(0, 1) == 1;
      ld_data  = 8'($urandom_range(0, 255));
      ld_done  = ($urandom_range(0, 31) == 0);
      step();
    end
    instr_ready = 1'b0; redirect = 1'b0; ld_valid = 1'b0; ld_done = 1'b0;

    do_redirect(32'h3C);
    wait_valid(4, "redirect_latency");
    check("wrap_pc", instr_pc, 32'h3C);
    check("wrap_instr", instr, 32'hB9BCBFC2);
    handshake();
    wait_valid(4, "wrap_next_latency");
    check("wrapped_pc", instr_pc, 32'h40);
    check("wrapped_instr", instr, 32'h01020304);

    handshake();
    step();
    step();
    do_redirect(32'h10);
    wait_valid(4, "midfetch_latency");
    check("midfetch_pc", instr_pc, 32'h10);
    check("midfetch_instr", instr, 32'h35383B3E);

    instr_ready = 1'b1;
    do_redirect(32'h20);
    instr_ready = 1'b0;
    check("redir_ready_drop", instr_valid, 1'b0);
    wait_valid(4, "redir_ready_latency");
    check("redir_ready_pc", instr_pc, 32'h20);
    check("redir_ready_instr", instr, 32'h65686B6E);

    do_redirect(32'h6);
    check("misalign_set", misalign_err, 1'b1);
    check("misalign_valid", instr_valid, 1'b0);
    redirect = 1'b1; redirect_pc = 32'h10;
    repeat (3) step();
    redirect = 1'b0;
    step();
    check("err_sticky", misalign_err, 1'b1);
    check("err_no_valid", instr_valid, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("async_clr_err", misalign_err, 1'b0);
    check("async_clr_instr", instr, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    if (LOADER) begin
      for (int i = 0; i < 3; i++) begin
        ld_valid = 1'b1; ld_data = 8'(8'hAA + 8'(i * 17));
        step();
      end
      ld_valid = 1'b0; rst_n = 1'b0;
      step();
      rst_n = 1'b1; ld_valid = 1'b1; ld_data = 8'h11;
      step();
      ld_valid = 1'b0; ld_done = 1'b1;
      step();
      ld_done = 1'b0;
      wait_valid(4, "reload_latency");
      check("reload_mem0", phys_mem[0], 8'h11);
      check("reload_instr", instr, 32'h11BBCC04);
      check("reload_pc", instr_pc, 32'h0);
    end else begin
      wait_valid(4, "post_reset_latency");
      check("post_reset_instr", instr, 32'h01020304);
      check("post_reset_pc", instr_pc, 32'h0);
    end
    step();

    check("scoreboard_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("scoreboard_word", got_q[i], exp_q[i]);
    for (int i = 0; i < DEPTH; i++) check("mem_contents", phys_mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Fetch sequencer for the byte-wide instruction memory (DEPTH bytes, 8-bit entries, big-endian word assembly, combinational read). It owns the single byte port of the memory and shares it between an optional boot loader (write) and instruction fetch (read). It assembles each 32-bit instruction over four byte reads and hands it to decode with a valid/ready handshake, with branch redirect and misalignment detection.

## Interface
- DEPTH, 64, instruction memory size in bytes; power of two; AW = $clog2(DEPTH)
- RESET_PC, 32'h0, PC after reset or after loader completion; must be 4-byte aligned
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_addr  out  AW  byte address to memory
- mem_rdata  in  8  memory byte at mem_addr, same cycle (combinational)
- mem_we  out  1  byte write strobe (loader only)
- mem_wdata  out  8  byte write data
- ld_valid  in  1  loader byte available
- ld_data  in  8  loader byte
- ld_ready  out  1  controller accepts loader byte
- ld_done  in  1  loader finished (single-cycle pulse)
- redirect  in  1  branch/jump redirect request
- redirect_pc  in  32  redirect target
- instr_valid  out  1  instr/instr_pc hold a complete instruction
- instr_ready  in  1  decode accepts instruction
- instr  out  32  assembled instruction
- instr_pc  out  32  byte address of instr
- misalign_err  out  1  sticky: redirect to non-word-aligned target

## Operation
- States: LOAD, FETCH, HOLD, ERR. Internal: pc[31:0], byte counter k[1:0], write pointer wptr[AW-1:0], word shift register.
- LOAD: ld_ready=1. On ld_valid: mem_we=1, mem_addr=wptr, mem_wdata=ld_data, wptr<=wptr+1 (wraps DEPTH-1 -> 0). On ld_done: go to FETCH with pc=RESET_PC and k=0. If ld_done and ld_valid occur together, the write completes first. redirect is ignored in LOAD.
- FETCH: mem_addr=(pc+k)[AW-1:0], so addresses wrap modulo DEPTH. Each cycle shifts mem_rdata into the word; byte k=0 lands in instr[31:24], k=3 in instr[7:0]. After k=3: instr_pc<=pc, instr_valid<=1, go to HOLD.
- HOLD: instr/instr_pc stay stable while instr_valid=1 and instr_ready=0. On instr_ready: pc<=pc+4 (32-bit wrap), k<=0, instr_valid<=0, go to FETCH.
- Redirect (FETCH/HOLD) has highest priority and aborts the partial fetch.
  - Held instruction is dropped: instr_valid=0 next cycle.
  - If redirect and instr_ready occur in the same cycle, the handshake counts as taken, but the next pc is redirect_pc.
  - Aligned target (redirect_pc[1:0]==0): pc<=redirect_pc, k<=0, go to FETCH.
  - Misaligned target: go to ERR.
- ERR: misalign_err=1, instr_valid=0, no memory access. Only reset exits ERR.
- mem_we=0 in every state except a LOAD cycle with ld_valid=1. ld_ready=0 outside LOAD.

## Timing
- Reset values: state=LOAD (FETCH without loader), pc=RESET_PC, k=0, wptr=0, instr_valid=0, instr=0, instr_pc=0, misalign_err=0, mem_we=0, mem_wdata=0.
- Loader: one byte per cycle, zero wait states.
- Fetch latency: first instr_valid rises 4 cycles after entering FETCH. Each later instruction arrives 5 cycles after the previous handshake: 1 handshake cycle plus 4 byte reads.
- Redirect: the fetch at the target starts the cycle after redirect is sampled. instr_valid rises 4 cycles after that.
- Asserting rst_n low mid-operation clears all state immediately, including partial words and misalign_err. Memory contents are untouched.

## Configuration
- IMEM_LOADER_EN defined: reset enters LOAD and the loader port is functional.
- IMEM_LOADER_EN undefined:
  - LOAD state and wptr are removed.
  - Reset enters FETCH at RESET_PC.
  - ld_ready, mem_we and mem_wdata are tied to 0; ld_* inputs are ignored.

## Test plan
- Loader (EN): write bytes 01,02,…,08 then pulse ld_done -> mem addresses 0..7 hold the bytes; instr=32'h01020304, instr_pc=0 at the 4th cycle after ld_done. With instr_ready=1: next instr=32'h05060708, instr_pc=4, exactly 5 cycles later.
- Backpressure: hold instr_ready=0 for 10 cycles -> instr/instr_pc stable, mem_addr frozen, no pc advance. Release -> pc+4.
- Wrap: redirect_pc=32'h3C with DEPTH=64 -> reads addresses 3C..3F. After the handshake, pc=32'h40 -> mem_addr=0, instr_pc=32'h40.
- Redirect mid-fetch at k=2 -> partial word discarded; next instr_pc=redirect_pc. Redirect together with instr_ready -> no duplicate or skipped valid.
- Misaligned redirect_pc=32'h6 -> misalign_err=1 next cycle, instr_valid=0. Further redirects are ignored. Async reset clears misalign_err.
- Reset asserted during LOAD after 3 bytes -> wptr=0; next loader byte written to address 0.
